// File: rtl/mcycle_sched_if.sv
// Request, multi-cycle-unit and write-back signals of the multi-cycle scheduler.
// The scheduler is the slave; the pipeline/unit environment is the master.
interface mcycle_sched_if #(
    parameter int unsigned WIDTH = 32
);
    logic             M_Start;
    logic             MCycleOp;
    logic             M_W;
    logic [3:0]       WA;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic             Flush;
    logic             MC_Done;
    logic [WIDTH-1:0] MC_Result;
    logic             MC_Start;
    logic             MC_Op;
    logic [WIDTH-1:0] MC_Operand1;
    logic [WIDTH-1:0] MC_Operand2;
    logic             Stall;
    logic             Busy;
    logic             WE;
    logic [3:0]       WA_out;
    logic [WIDTH-1:0] WD;
    logic             Timeout;
    logic [7:0]       LastCycles;

    modport slave (
        input  M_Start, MCycleOp, M_W, WA, Operand1, Operand2, Flush, MC_Done, MC_Result,
        output MC_Start, MC_Op, MC_Operand1, MC_Operand2, Stall, Busy, WE, WA_out, WD,
               Timeout, LastCycles
    );

    modport master (
        output M_Start, MCycleOp, M_W, WA, Operand1, Operand2, Flush, MC_Done, MC_Result,
        input  MC_Start, MC_Op, MC_Operand1, MC_Operand2, Stall, Busy, WE, WA_out, WD,
               Timeout, LastCycles
    );
endinterface

// File: rtl/mcycle_sched.sv
// Sequences one MUL/DIV at a time through an external multi-cycle unit, stalling
// the pipeline until write-back, with flush handling and a WAIT-cycle watchdog.
module mcycle_sched #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MAX_CYCLES = 64
) (
    input  logic          CLK,
    input  logic          Reset,
    mcycle_sched_if.slave bus
);
    localparam int unsigned      CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, WB, DRAIN} state_t;

    state_t           state_q;
    state_t           state_d;
    logic             accept_c;
    logic             wb_go_c;
    logic             timeout_go_c;
    logic             stall_c;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] last_q;
    logic             mc_start_q;
    logic             op_q;
    logic             m_w_q;
    logic             we_q;
    logic             timeout_q;
    logic [3:0]       wa_q;
    logic [3:0]       wa_out_q;
    logic [WIDTH-1:0] opnd1_q;
    logic [WIDTH-1:0] opnd2_q;
    logic [WIDTH-1:0] wd_q;

    // One bit wider so a saturated count cannot wrap into a false watchdog match
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, pipeline stall and datapath load strobes
    always_comb begin
        state_d      = state_q;
        accept_c     = 1'b0;
        wb_go_c      = 1'b0;
        timeout_go_c = 1'b0;
        stall_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.M_Start && !bus.Flush) begin
                    accept_c = 1'b1;
                    stall_c  = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                stall_c = 1'b1;
                state_d = bus.Flush ? IDLE : WAIT;
            end
            WAIT: begin
                stall_c = 1'b1;
                if (bus.Flush) begin
                    // A flushed op still owns the unit until it reports done
                    state_d = bus.MC_Done ? IDLE : DRAIN;
                end else if (bus.MC_Done) begin
                    wb_go_c = 1'b1;
                    state_d = WB;
                end else if (cnt_inc == (CNT_W + 1)'(MAX_CYCLES)) begin
                    timeout_go_c = 1'b1;
                    state_d      = DRAIN;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            DRAIN: begin
                stall_c = bus.M_Start;
                if (bus.MC_Done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            mc_start_q <= 1'b0;
            op_q       <= 1'b0;
            opnd1_q    <= '0;
            opnd2_q    <= '0;
            m_w_q      <= 1'b0;
            wa_q       <= '0;
            we_q       <= 1'b0;
            wa_out_q   <= '0;
            wd_q       <= '0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
            last_q     <= '0;
        end else begin
            mc_start_q <= accept_c;
            we_q       <= wb_go_c & m_w_q;
            timeout_q  <= timeout_go_c;
            if (accept_c) begin
                op_q    <= bus.MCycleOp;
                opnd1_q <= bus.Operand1;
                opnd2_q <= bus.Operand2;
                m_w_q   <= bus.M_W;
                wa_q    <= bus.WA;
            end
            if (state_q == LAUNCH) begin
                cnt_q <= '0;
            end else if (state_q == WAIT && cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (wb_go_c) begin
                wd_q     <= bus.MC_Result;
                last_q   <= cnt_inc[CNT_W-1:0];
                wa_out_q <= wa_q;
            end
        end
    end

    // Launch pulse is withdrawn when the op is flushed in its LAUNCH cycle
    assign bus.MC_Start    = mc_start_q & ~bus.Flush;
    assign bus.MC_Op       = op_q;
    assign bus.MC_Operand1 = opnd1_q;
    assign bus.MC_Operand2 = opnd2_q;
    assign bus.Stall       = stall_c;
    assign bus.Busy        = (state_q != IDLE);
    assign bus.WE          = we_q;
    assign bus.WA_out      = wa_out_q;
    assign bus.WD          = wd_q;
    assign bus.Timeout     = timeout_q;
    assign bus.LastCycles  = last_q;
endmodule

// File: tb/tb_mcycle_sched.sv
// Bench for mcycle_sched: table of MUL/DIV ops run back-to-back against a
// behavioural multi-cycle unit, write-back scoreboard, and hand-built corner sequences.
module tb_mcycle_sched;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned MAX_CYC = 8;
    localparam int          NV      = 6;

    typedef struct {
        logic             op;
        logic             mw;
        logic [3:0]       wa;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int               dly;
        logic             dil;
        logic [WIDTH-1:0] exp_wd;
        logic [7:0]       exp_last;
    } vec_t;

    typedef struct {
        logic [3:0]       wa;
        logic [WIDTH-1:0] wd;
        logic [7:0]       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mcycle_sched_if #(.WIDTH(WIDTH)) bus ();

    mcycle_sched #(.WIDTH(WIDTH), .MAX_CYCLES(MAX_CYC)) dut (
        .CLK  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    int               n_tests       = 0;
    int               n_fail        = 0;
    int               cycle         = 0;
    int               mc_start_seen = 0;
    int               last_we_cycle = 0;
    bit               we_seen       = 1'b0;
    exp_t             sb[$];
    logic [WIDTH-1:0] exp_wd_hold;
    logic [7:0]       exp_last_hold;
    vec_t             vt[NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Behavioural multi-cycle unit, fed from what the scheduler actually launched
    function automatic logic [WIDTH-1:0] unit_model();
        logic [WIDTH-1:0] r;
        if (bus.MC_Op) begin
            r = (bus.MC_Operand2 == '0) ? '1 : bus.MC_Operand1 / bus.MC_Operand2;
        end else begin
            r = bus.MC_Operand1 * bus.MC_Operand2;
        end
        return r;
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Write-back scoreboard and launch-spacing monitor
    always @(negedge clk) begin
        if (bus.MC_Start) begin
            mc_start_seen++;
            if (we_seen) check("start_gap_after_we", 64'((cycle - last_we_cycle) >= 2), 64'(1));
        end
        if (bus.WE) begin
            if (sb.size() == 0) begin
                check("we_unexpected", 64'(bus.WE), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_wa_out", 64'(bus.WA_out), 64'(e.wa));
                check("sb_wd", 64'(bus.WD), 64'(e.wd));
                check("sb_last_cycles", 64'(bus.LastCycles), 64'(e.last));
            end
            last_we_cycle = cycle;
            we_seen       = 1'b1;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_req();
        bus.M_Start   = 1'b0;
        bus.MCycleOp  = 1'b0;
        bus.M_W       = 1'b0;
        bus.WA        = '0;
        bus.Operand1  = '0;
        bus.Operand2  = '0;
        bus.Flush     = 1'b0;
        bus.MC_Done   = 1'b0;
        bus.MC_Result = '0;
    endtask

    task automatic drive_req(input vec_t v);
        bus.M_Start  = 1'b1;
        bus.MCycleOp = v.op;
        bus.M_W      = v.mw;
        bus.WA       = v.wa;
        bus.Operand1 = v.a;
        bus.Operand2 = v.b;
    endtask

    // Accept cycle: DUT is expected to be IDLE here
    task automatic accept_op(input vec_t v, input bit push);
        next_cycle();
        drive_req(v);
        bus.Flush     = 1'b0;
        bus.MC_Done   = 1'b0;
        bus.MC_Result = '0;
        sample();
        check("stall_accept", 64'(bus.Stall), 64'(1));
        check("busy_accept", 64'(bus.Busy), 64'(0));
        if (push && v.mw) sb.push_back('{v.wa, v.exp_wd, v.exp_last});
    endtask

    // LAUNCH through WB; optionally presents the next request during WB
    task automatic complete_op(input vec_t v, input bit next_req, input vec_t nv);
        int starts0;
        starts0 = mc_start_seen;
        next_cycle();
        bus.M_Start   = 1'b0;
        bus.MCycleOp  = ~v.op;
        bus.M_W       = ~v.mw;
        bus.WA        = ~v.wa;
        bus.Operand1  = $urandom;
        bus.Operand2  = $urandom;
        bus.MC_Done   = v.dil;
        bus.MC_Result = 32'hDEAD_BEEF;
        sample();
        check("launch_mc_start", 64'(bus.MC_Start), 64'(1));
        check("launch_mc_op", 64'(bus.MC_Op), 64'(v.op));
        check("launch_operand1", 64'(bus.MC_Operand1), 64'(v.a));
        check("launch_operand2", 64'(bus.MC_Operand2), 64'(v.b));
        check("launch_stall", 64'(bus.Stall), 64'(1));
        for (int i = 1; i < v.dly; i++) begin
            next_cycle();
            bus.MC_Done = 1'b0;
            sample();
            check("wait_stall", 64'(bus.Stall), 64'(1));
        end
        next_cycle();
        bus.MC_Done   = 1'b1;
        bus.MC_Result = unit_model();
        sample();
        check("done_stall", 64'(bus.Stall), 64'(1));
        check("done_no_we", 64'(bus.WE), 64'(0));
        next_cycle();
        bus.MC_Done   = 1'b0;
        bus.MC_Result = '0;
        if (next_req) drive_req(nv);
        sample();
        check("wb_stall", 64'(bus.Stall), 64'(0));
        check("wb_busy", 64'(bus.Busy), 64'(1));
        check("wb_we", 64'(bus.WE), 64'(v.mw));
        check("wb_wa_out", 64'(bus.WA_out), 64'(v.wa));
        check("wb_wd", 64'(bus.WD), 64'(v.exp_wd));
        check("wb_last_cycles", 64'(bus.LastCycles), 64'(v.exp_last));
        check("mc_start_count", 64'(mc_start_seen - starts0), 64'(1));
        exp_wd_hold   = v.exp_wd;
        exp_last_hold = v.exp_last;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vto;
        vec_t vfl;
        vec_t vn;
        vec_t vr;
        int   s0;

        //          op    mw    wa     a              b             dly dil   exp_wd         last
        vt[0] = '{1'b0, 1'b1, 4'd3,  32'd7,         32'd6,         3, 1'b0, 32'd42,        8'd3};
        vt[1] = '{1'b0, 1'b1, 4'd5,  32'h0001_0000, 32'h0001_0000, 1, 1'b0, 32'd0,         8'd1};
        vt[2] = '{1'b1, 1'b1, 4'd15, 32'd100,       32'd7,         7, 1'b0, 32'd14,        8'd7};
        vt[3] = '{1'b0, 1'b0, 4'd2,  32'd3,         32'd3,         2, 1'b1, 32'd9,         8'd2};
        vt[4] = '{1'b1, 1'b1, 4'd0,  32'hFFFF_FFFF, 32'd1,         4, 1'b0, 32'hFFFF_FFFF, 8'd4};
        vt[5] = '{1'b0, 1'b1, 4'd9,  32'hFFFF_FFFF, 32'd2,         5, 1'b0, 32'hFFFF_FFFE, 8'd5};
        vto   = '{1'b1, 1'b1, 4'd1,  32'd50,        32'd5,         0, 1'b0, 32'd10,        8'd0};
        vfl   = '{1'b0, 1'b1, 4'd4,  32'd8,         32'd8,         0, 1'b0, 32'd64,        8'd0};
        vn    = '{1'b0, 1'b1, 4'd6,  32'd5,         32'd5,         2, 1'b0, 32'd25,        8'd2};
        vr    = '{1'b0, 1'b1, 4'd7,  32'd2,         32'd3,         0, 1'b0, 32'd6,         8'd0};

        rst = 1'b1;
        clear_req();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sample();
        check("rst_busy", 64'(bus.Busy), 64'(0));
        check("rst_stall", 64'(bus.Stall), 64'(0));
        check("rst_mc_start", 64'(bus.MC_Start), 64'(0));
        check("rst_mc_op", 64'(bus.MC_Op), 64'(0));
        check("rst_operand1", 64'(bus.MC_Operand1), 64'(0));
        check("rst_we", 64'(bus.WE), 64'(0));
        check("rst_wa_out", 64'(bus.WA_out), 64'(0));
        check("rst_wd", 64'(bus.WD), 64'(0));
        check("rst_timeout", 64'(bus.Timeout), 64'(0));
        check("rst_last_cycles", 64'(bus.LastCycles), 64'(0));
        exp_wd_hold   = '0;
        exp_last_hold = '0;

        // Table of ops, each next request already raised in the previous WB cycle
        for (int i = 0; i < NV; i++) begin
            accept_op(vt[i], 1'b1);
            complete_op(vt[i], i < NV - 1, vt[(i < NV - 1) ? i + 1 : i]);
        end

        // DIV whose unit never answers: watchdog after MAX_CYC WAIT cycles
        accept_op(vto, 1'b0);
        next_cycle();
        clear_req();
        sample();
        check("to_launch_start", 64'(bus.MC_Start), 64'(1));
        for (int i = 0; i < int'(MAX_CYC); i++) begin
            next_cycle();
            sample();
            check("to_wait_timeout", 64'(bus.Timeout), 64'(0));
            check("to_wait_stall", 64'(bus.Stall), 64'(1));
        end
        next_cycle();
        sample();
        check("to_pulse", 64'(bus.Timeout), 64'(1));
        check("to_busy", 64'(bus.Busy), 64'(1));
        check("to_no_we", 64'(bus.WE), 64'(0));
        check("to_stall", 64'(bus.Stall), 64'(0));
        check("to_last_hold", 64'(bus.LastCycles), 64'(exp_last_hold));
        next_cycle();
        sample();
        check("to_pulse_end", 64'(bus.Timeout), 64'(0));
        check("to_drain_busy", 64'(bus.Busy), 64'(1));
        next_cycle();
        bus.MC_Done   = 1'b1;
        bus.MC_Result = 32'd10;
        sample();
        check("to_drain_done_busy", 64'(bus.Busy), 64'(1));
        next_cycle();
        bus.MC_Done = 1'b0;
        sample();
        check("to_idle_busy", 64'(bus.Busy), 64'(0));
        check("to_idle_we", 64'(bus.WE), 64'(0));
        check("to_idle_wd", 64'(bus.WD), 64'(exp_wd_hold));
        check("to_idle_last", 64'(bus.LastCycles), 64'(exp_last_hold));

        // Flush in the 2nd WAIT cycle, new request held through DRAIN
        accept_op(vfl, 1'b0);
        next_cycle();
        clear_req();
        sample();
        check("fl_launch_start", 64'(bus.MC_Start), 64'(1));
        next_cycle();
        sample();
        check("fl_wait1_stall", 64'(bus.Stall), 64'(1));
        next_cycle();
        bus.Flush = 1'b1;
        sample();
        check("fl_wait2_stall", 64'(bus.Stall), 64'(1));
        next_cycle();
        bus.Flush = 1'b0;
        drive_req(vn);
        sample();
        check("fl_drain_stall", 64'(bus.Stall), 64'(1));
        check("fl_drain_busy", 64'(bus.Busy), 64'(1));
        check("fl_drain_we", 64'(bus.WE), 64'(0));
        next_cycle();
        bus.MC_Done   = 1'b1;
        bus.MC_Result = 32'd99;
        sample();
        check("fl_drain_done_stall", 64'(bus.Stall), 64'(1));
        check("fl_drain_done_busy", 64'(bus.Busy), 64'(1));
        check("fl_drain_no_start", 64'(bus.MC_Start), 64'(0));
        accept_op(vn, 1'b1);
        check("fl_wd_discarded", 64'(bus.WD), 64'(exp_wd_hold));
        check("fl_last_hold", 64'(bus.LastCycles), 64'(exp_last_hold));
        complete_op(vn, 1'b0, vn);

        // Flush in LAUNCH: launch withdrawn, stray done afterwards ignored
        accept_op(vfl, 1'b0);
        s0 = mc_start_seen;
        next_cycle();
        clear_req();
        bus.Flush = 1'b1;
        sample();
        check("fll_mc_start", 64'(bus.MC_Start), 64'(0));
        check("fll_busy", 64'(bus.Busy), 64'(1));
        next_cycle();
        bus.Flush     = 1'b0;
        bus.MC_Done   = 1'b1;
        bus.MC_Result = 32'h77;
        sample();
        check("fll_idle_busy", 64'(bus.Busy), 64'(0));
        next_cycle();
        bus.MC_Done = 1'b0;
        sample();
        check("fll_stray_busy", 64'(bus.Busy), 64'(0));
        check("fll_stray_wd", 64'(bus.WD), 64'(exp_wd_hold));
        check("fll_start_count", 64'(mc_start_seen - s0), 64'(0));

        // M_Start together with Flush in IDLE is not accepted
        next_cycle();
        drive_req(vt[0]);
        bus.Flush = 1'b1;
        sample();
        check("sf_stall", 64'(bus.Stall), 64'(0));
        check("sf_busy", 64'(bus.Busy), 64'(0));
        next_cycle();
        clear_req();
        sample();
        check("sf_busy_after", 64'(bus.Busy), 64'(0));
        check("sf_no_start", 64'(bus.MC_Start), 64'(0));

        // Reset in WAIT (with a competing request), then a stray done
        accept_op(vr, 1'b0);
        next_cycle();
        clear_req();
        sample();
        next_cycle();
        sample();
        check("rw_wait_busy", 64'(bus.Busy), 64'(1));
        next_cycle();
        rst = 1'b1;
        drive_req(vr);
        sample();
        next_cycle();
        rst = 1'b0;
        clear_req();
        bus.MC_Done   = 1'b1;
        bus.MC_Result = 32'd6;
        sample();
        check("rw_busy", 64'(bus.Busy), 64'(0));
        check("rw_we", 64'(bus.WE), 64'(0));
        check("rw_wd", 64'(bus.WD), 64'(0));
        check("rw_last", 64'(bus.LastCycles), 64'(0));
        check("rw_timeout", 64'(bus.Timeout), 64'(0));
        check("rw_operand1", 64'(bus.MC_Operand1), 64'(0));
        next_cycle();
        clear_req();
        sample();
        check("rw_busy_after", 64'(bus.Busy), 64'(0));
        check("rw_we_after", 64'(bus.WE), 64'(0));
        check("rw_wd_after", 64'(bus.WD), 64'(0));
        exp_wd_hold   = '0;
        exp_last_hold = '0;

        // Normal op after the mid-operation reset
        accept_op(vt[0], 1'b1);
        complete_op(vt[0], 1'b0, vt[0]);

        next_cycle();
        clear_req();
        repeat (2) sample();
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mcycle_sched.md
MCYCLE_SCHED -- requirements
Module: mcycle_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter MAX_CYCLES, default 64, watchdog limit in WAIT cycles (2..255).
REQ-003 SHALL have ports:
- CLK  in  1  sole clock, rising edge.
- Reset  in  1  synchronous, active-high.
- M_Start  in  1  decoder multi-cycle request, already condition-qualified.
- MCycleOp  in  1  0 = MUL, 1 = DIV.
- M_W  in  1  result writes register file.
- WA  in  4  destination register.
- Operand1, Operand2  in  WIDTH  source operands.
- Flush  in  1  pipeline flush; cancels the current op.
- MC_Done  in  1  one-cycle completion pulse from the multi-cycle unit.
- MC_Result  in  WIDTH  unit result, valid with MC_Done.
- MC_Start  out  1  one-cycle launch pulse to the unit.
- MC_Op  out  1  latched op to the unit.
- MC_Operand1, MC_Operand2  out  WIDTH  latched operands to the unit.
- Stall  out  1  freeze the fetch/decode/execute stages.
- Busy  out  1  state not IDLE.
- WE  out  1  register-file write pulse.
- WA_out  out  4  write address.
- WD  out  WIDTH  write data.
- Timeout  out  1  one-cycle watchdog pulse.
- LastCycles  out  8  WAIT-cycle count of the last completed op.

Function
REQ-004 SHALL implement the FSM states IDLE, LAUNCH, WAIT, WB and DRAIN.
REQ-005 IDLE: on M_Start=1 with Flush=0, SHALL latch MCycleOp, M_W, WA, Operand1 and Operand2, then go to LAUNCH; otherwise SHALL stay in IDLE.
REQ-006 Stall SHALL be combinational and equal 1 when any of the following holds:
- state IDLE with M_Start=1 and Flush=0;
- state LAUNCH or WAIT;
- state DRAIN with M_Start=1.
REQ-007 Stall SHALL be 0 in WB, so the stalled instruction retires in the write-back cycle.
REQ-008 LAUNCH: MC_Start SHALL be 1 for exactly this one cycle; the cycle counter SHALL clear to 0; next state SHALL be WAIT.
REQ-009 MC_Op, MC_Operand1 and MC_Operand2 SHALL hold the latched values from LAUNCH until the next acceptance.
REQ-010 MC_Done asserted in LAUNCH SHALL be ignored.
REQ-011 WAIT: the counter SHALL increment by 1 each cycle, saturating at 255.
REQ-012 WAIT with MC_Done=1: SHALL capture MC_Result into WD, load LastCycles with counter+1, and go to WB.
REQ-013 WAIT with MC_Done=0 and counter+1 == MAX_CYCLES: SHALL pulse Timeout for 1 cycle, perform no write, leave LastCycles unchanged, and go to DRAIN.
REQ-014 WB: WE SHALL equal the latched M_W for exactly one cycle, with WA_out = latched WA; next state SHALL be IDLE.
REQ-015 WE SHALL be 0 in every state other than WB.
REQ-016 Flush=1 in LAUNCH SHALL suppress MC_Start and return the FSM to IDLE.
REQ-017 Flush=1 in WAIT with MC_Done=0 SHALL go to DRAIN with no write.
REQ-018 Flush=1 in WAIT with MC_Done=1 SHALL go to IDLE with no write and leave LastCycles unchanged.
REQ-019 Flush SHALL be ignored in WB; the write completes.
REQ-020 DRAIN: SHALL wait for MC_Done, discard MC_Result, then go to IDLE.
REQ-021 DRAIN SHALL accept no new request; a pending M_Start is held by Stall until IDLE.
REQ-022 Busy SHALL equal 1 in every state other than IDLE.
REQ-023 Latency: a MUL accepted at cycle 0 with MC_Done at cycle k+1 (k ≥ 1) SHALL produce WE at cycle k+2, with LastCycles = k.
REQ-024 Back-to-back requests SHALL be accepted no earlier than the cycle after WB, and at most one op SHALL be outstanding at the unit at any time.

Reset
REQ-025 Reset=1 at a rising edge SHALL force IDLE, clear the counter and LastCycles, and drive every registered output to 0.
REQ-026 The registered outputs cleared by Reset are MC_Start, MC_Op, MC_Operand1, MC_Operand2, WE, WA_out, WD and Timeout.
REQ-027 Reset mid-operation (LAUNCH, WAIT, DRAIN or WB) SHALL abort with no write; a subsequent stray MC_Done in IDLE SHALL be ignored.
REQ-028 Reset SHALL take priority over M_Start, Flush and MC_Done in the same cycle.

Verification
REQ-029 SHALL cover a MUL with M_W=1, WA=3, operands 7 and 6, and MC_Done with 42 three cycles after MC_Start: exactly one MC_Start pulse; Stall high from the accept cycle through WAIT; WE=1, WA_out=3, WD=42 for one cycle; LastCycles=3.
REQ-030 SHALL cover a DIV with MC_Done never asserted and MAX_CYCLES=8: Timeout pulses after 8 WAIT cycles with no WE; a later MC_Done returns the FSM to IDLE.
REQ-031 SHALL cover Flush at the 2nd WAIT cycle, then MC_Done with 99: no WE; DRAIN is entered; a new M_Start raised during DRAIN is stalled and accepted in the cycle after DRAIN exits.
REQ-032 SHALL cover M_Start and Flush in the same IDLE cycle: no acceptance, Stall=0, Busy stays 0.
REQ-033 SHALL cover Reset asserted in WAIT, then MC_Done: Busy=0, and WE, WD, LastCycles and Timeout all 0.
REQ-034 SHALL cover two back-to-back MULs: the second MC_Start occurs no earlier than 2 cycles after the first WE, and WD values match each op in order.
